// File: rtl/mem_lsu_pkg.sv
// Shared LSU definitions: FSM states, funct3 size codes, size helper.
package mem_lsu_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Low two bits encode access size: 00 byte, 01 half, else word.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores, extract/extend for loads, misalign detect.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] b2,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [31:0] sh;

    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        wdata    = b2;
        wstrb    = 4'b1111;
        ld_data  = sh;
        misalign = 1'b0;
        case (f3_size(funct3))
            2'b00: begin
                wdata   = {4{b2[7:0]}};
                wstrb   = 4'b0001 << off;
                ld_data = funct3[2] ? {24'b0, sh[7:0]}
                                    : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                wdata    = {2{b2[15:0]}};
                wstrb    = 4'b0011 << off;
                ld_data  = funct3[2] ? {16'b0, sh[15:0]}
                                     : {{16{sh[15]}}, sh[15:0]};
                misalign = off[0];
            end
            default: begin
                misalign = |off;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one outstanding valid/ready request,
// pipeline stall until the access completes.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MEM_ld,
    input  logic                MEM_str,
    input  logic [2:0]          MEM_funct3,
    input  logic [XLEN-1:0]     MEM_alu_out,
    input  logic [XLEN-1:0]     MEM_b2,
    output logic [XLEN-1:0]     MEM_data_mem,
    output logic                MEM_stall,
    output logic                MEM_misalign,
    output logic                req_valid,
    input  logic                req_ready,
    output logic                req_we,
    output logic [ADDR_W-3:0]   req_addr,
    output logic [XLEN-1:0]     req_wdata,
    output logic [XLEN/8-1:0]   req_wstrb,
    input  logic                rsp_valid,
    input  logic [XLEN-1:0]     rsp_rdata
);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] result;

    logic        idle;
    logic        cmd;
    logic        go;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_ld;
    logic        al_mis;

    assign idle = (state == S_IDLE);
    assign cmd  = MEM_ld | MEM_str;
    assign go   = idle & cmd & ~al_mis;

    // Live command in IDLE, latched copy once the access is in flight.
    assign f3_sel  = idle ? MEM_funct3 : f3_q;
    assign off_sel = idle ? MEM_alu_out[1:0] : off_q;

    lsu_align u_align (
        .funct3   (f3_sel),
        .off      (off_sel),
        .b2       (MEM_b2),
        .rdata    (rsp_rdata),
        .wdata    (al_wdata),
        .wstrb    (al_wstrb),
        .ld_data  (al_ld),
        .misalign (al_mis)
    );

    assign MEM_misalign = idle & cmd & al_mis;
    assign MEM_stall    = go | (state == S_REQ) | (state == S_WAIT);
    assign MEM_data_mem = (state == S_DONE && !req_we) ? result
                                                       : MEM_alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            f3_q      <= 3'b0;
            off_q     <= 2'b0;
            result    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        req_valid <= 1'b1;
                        req_we    <= ~MEM_ld;
                        req_addr  <= MEM_alu_out[ADDR_W-1:2];
                        req_wdata <= MEM_ld ? '0 : al_wdata;
                        req_wstrb <= MEM_ld ? '0 : al_wstrb;
                        f3_q      <= MEM_funct3;
                        off_q     <= MEM_alu_out[1:0];
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= req_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        result <= al_ld;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a byte-level reference model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MEM_ld = 1'b0;
    logic        MEM_str = 1'b0;
    logic [2:0]  MEM_funct3 = 3'b0;
    logic [31:0] MEM_alu_out = '0;
    logic [31:0] MEM_b2 = '0;
    logic [31:0] MEM_data_mem;
    logic        MEM_stall;
    logic        MEM_misalign;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_we;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;

    int nvec = 0;
    int nerr = 0;

    mem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MEM_ld       (MEM_ld),
        .MEM_str      (MEM_str),
        .MEM_funct3   (MEM_funct3),
        .MEM_alu_out  (MEM_alu_out),
        .MEM_b2       (MEM_b2),
        .MEM_data_mem (MEM_data_mem),
        .MEM_stall    (MEM_stall),
        .MEM_misalign (MEM_misalign),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f3,
                                   input logic [31:0] a);
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3,
                                          input logic [31:0] a);
        logic [3:0] s;
        int o = int'(a % 4);
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) s[i] = (i >= o) && (i < o + n);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] b);
        logic [31:0] w;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = b[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v = '0;
        int o = int'(a % 4);
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
        if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic do_op(input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rd,
                         input int rdy, input int rsp);
        logic mis;
        @(negedge clk);
        MEM_ld = ld; MEM_str = st; MEM_funct3 = f3;
        MEM_alu_out = a; MEM_b2 = b;
        req_ready = 1'b0; rsp_valid = 1'($urandom % 2);
        rsp_rdata = $urandom;
        #1;
        if (!(ld | st)) begin
            chk("nop_stall", MEM_stall, 0);
            chk("nop_data", MEM_data_mem, a);
            chk("nop_rv", req_valid, 0);
            chk("nop_mis", MEM_misalign, 0);
            return;
        end
        mis = m_mis(f3, a);
        chk("misalign", MEM_misalign, mis);
        chk("stall_idle", MEM_stall, !mis);
        if (mis) begin
            chk("mis_data", MEM_data_mem, a);
            @(negedge clk);
            MEM_ld = 1'b0; MEM_str = 1'b0;
            #1;
            chk("mis_rv", req_valid, 0);
            return;
        end
        for (int k = 0; k <= rdy; k++) begin
            @(negedge clk);
            req_ready = (k == rdy);
            rsp_valid = 1'($urandom % 2);
            #1;
            chk("req_valid", req_valid, 1);
            chk("req_addr", req_addr, a >> 2);
            chk("req_we", req_we, !ld);
            chk("req_wstrb", req_wstrb, ld ? 4'b0 : m_strb(f3, a));
            if (!ld) chk("req_wdata", req_wdata, m_wdata(f3, b));
            chk("stall_req", MEM_stall, 1);
        end
        if (ld) begin
            for (int k = 0; k <= rsp; k++) begin
                @(negedge clk);
                req_ready = 1'b0;
                rsp_valid = (k == rsp);
                rsp_rdata = (k == rsp) ? rd : $urandom;
                #1;
                chk("wait_rv", req_valid, 0);
                chk("stall_wait", MEM_stall, 1);
            end
        end
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'($urandom % 2);
        rsp_rdata = $urandom;
        #1;
        chk("stall_done", MEM_stall, 0);
        chk("done_rv", req_valid, 0);
        chk("done_data", MEM_data_mem, ld ? m_load(f3, a, rd) : a);
        MEM_ld = 1'b0; MEM_str = 1'b0;
    endtask

    logic [2:0] f3tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rv", req_valid, 0);
        chk("rst_we", req_we, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_wdata", req_wdata, 0);
        chk("rst_wstrb", req_wstrb, 0);
        chk("rst_stall", MEM_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
        do_op(1, 0, 3'b000, 32'h13, 0, 32'h80FF_0000, 0, 0);
        do_op(1, 0, 3'b100, 32'h13, 0, 32'h80FF_0000, 0, 0);
        do_op(1, 0, 3'b101, 32'h12, 0, 32'h80FF_0000, 0, 0);
        do_op(0, 1, 3'b001, 32'h06, 32'h1234, 0, 0, 0);
        do_op(1, 0, 3'b010, 32'h02, 0, 0, 0, 0);
        do_op(1, 0, 3'b010, 32'h20, 0, 32'hCAFE_F00D, 3, 2);
        do_op(1, 1, 3'b000, 32'h31, 32'h77, 32'h0000_AB00, 1, 0);

        // Reset while waiting for the read response.
        @(negedge clk);
        MEM_ld = 1'b1; MEM_funct3 = 3'b010; MEM_alu_out = 32'h40;
        @(negedge clk);
        req_ready = 1'b1;
        #1 chk("r5_rv", req_valid, 1);
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b0;
        #1 chk("r5_wait", MEM_stall, 1);
        @(negedge clk);
        rst_n = 1'b0; MEM_ld = 1'b0;
        #1;
        chk("r5_rst_rv", req_valid, 0);
        chk("r5_rst_stall", MEM_stall, 0);
        @(negedge clk);
        rst_n = 1'b1; rsp_valid = 1'b1;
        rsp_rdata = 32'h1234_5678; MEM_alu_out = 32'h77;
        #1;
        chk("r5_data", MEM_data_mem, 32'h77);
        chk("r5_stall", MEM_stall, 0);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("r5_data2", MEM_data_mem, 32'h77);
        chk("r5_rv2", req_valid, 0);
        chk("r5_stall2", MEM_stall, 0);

        for (int i = 0; i < 8; i++)
            do_op(0, 0, 3'b000, 32'h55, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            int op = int'($urandom % 3);
            logic [2:0] f3 = f3tab[$urandom % 5];
            if (op == 1) f3 = f3tab[$urandom % 3];
            do_op(op == 0, op == 1, f3, $urandom & 32'h3FF,
                  $urandom, $urandom, int'($urandom % 4),
                  int'($urandom % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
